// File: rtl/tetris_board_renderer_pkg.sv
// Shared types and constants for the Tetris board renderer.
//   - board geometry (BOARD_W x BOARD_H cells)
//   - cell colour codes and cursor coordinate types
//   - bulk-operation FSM state encoding
//   - palette lookup and frame/background colours
package tetris_pkg;

    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;

    typedef logic [3:0] col_t;
    typedef logic [4:0] row_t;

    localparam col_t LAST_COL = col_t'(BOARD_W - 1);
    localparam row_t LAST_ROW = row_t'(BOARD_H - 1);

    typedef enum logic [2:0] {EMPTY, I, O, T, S, Z, J, L} cell_color_t;

    typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_SHIFT, ST_ZERO_TOP} bulk_state_t;

    localparam logic [23:0] RGB_BORDER     = 24'h808080;
    localparam logic [23:0] RGB_BACKGROUND = 24'h000000;

    function automatic logic [23:0] palette(input cell_color_t c);
        logic [23:0] rgb;
        case (c)
            EMPTY:   rgb = 24'h202020;
            I:       rgb = 24'h00FFFF;
            O:       rgb = 24'hFFFF00;
            T:       rgb = 24'hA000F0;
            S:       rgb = 24'h00F000;
            Z:       rgb = 24'hF00000;
            J:       rgb = 24'h0000F0;
            L:       rgb = 24'hF0A000;
            default: rgb = RGB_BACKGROUND;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/tetris_board_renderer_if.sv
// Game-logic side bus of the board renderer.
//   wr_valid/wr_ready/wr_col/wr_row/wr_color : single-cell write handshake
//   clr_req, shift_req/shift_row             : bulk operation requests (pulses)
//   busy, op_done                            : bulk operation status
// master = game logic, slave = renderer.
interface tetris_board_renderer_if;
    import tetris_pkg::*;

    logic        wr_valid;
    logic        wr_ready;
    col_t        wr_col;
    row_t        wr_row;
    logic [2:0]  wr_color;
    logic        clr_req;
    logic        shift_req;
    row_t        shift_row;
    logic        busy;
    logic        op_done;

    modport master (
        output wr_valid, wr_col, wr_row, wr_color, clr_req, shift_req, shift_row,
        input  wr_ready, busy, op_done
    );

    modport slave (
        input  wr_valid, wr_col, wr_row, wr_color, clr_req, shift_req, shift_row,
        output wr_ready, busy, op_done
    );

endinterface

// File: rtl/tetris_board_renderer_bulk_fsm.sv
// Bulk-operation sequencer for the playfield (clear-all, row collapse).
// Owns the state, cell cursor, busy and op_done; emits one cell-write
// command per cycle to the storage in the top level.
//   clk, reset        : clock, synchronous active-high reset
//   i_clr_req         : start clear-all
//   i_shift_req/row   : start collapse onto i_shift_row
//   o_busy, o_op_done : status; o_wr_ready : single-cell port may accept
//   o_cmd_*           : cell write command (row, col, source = zero or row above)
//
// state       | meaning
// ST_IDLE     | waiting for a request, write port open
// ST_CLEAR    | zeroing every cell, row-major from (0,0)
// ST_SHIFT    | copying row r-1 into row r, walking r down to 1
// ST_ZERO_TOP | zeroing row 0 after a collapse
module board_bulk_fsm
    import tetris_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_clr_req,
    input  logic i_shift_req,
    input  row_t i_shift_row,
    output logic o_busy,
    output logic o_op_done,
    output logic o_wr_ready,
    output logic o_cmd_we,
    output logic o_cmd_from_above,
    output row_t o_cmd_row,
    output col_t o_cmd_col
);

    bulk_state_t r_state, w_state_nxt;
    row_t        r_row, w_row_nxt;
    col_t        r_col, w_col_nxt;
    logic        r_op_done, w_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_row     <= '0;
            r_col     <= '0;
            r_op_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_row     <= w_row_nxt;
            r_col     <= w_col_nxt;
            r_op_done <= w_done;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Clear has priority; an out-of-range collapse row is dropped.
                if (i_clr_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                end else if (i_shift_req && (i_shift_row <= LAST_ROW)) begin
                    w_state_nxt = (i_shift_row == '0) ? ST_ZERO_TOP : ST_SHIFT;
                    w_row_nxt   = i_shift_row;
                    w_col_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                if (r_col == LAST_COL) begin
                    w_col_nxt = '0;
                    if (r_row == LAST_ROW) begin
                        w_state_nxt = ST_IDLE;
                        w_row_nxt   = '0;
                        w_done      = 1'b1;
                    end else begin
                        w_row_nxt = r_row + row_t'(1);
                    end
                end else begin
                    w_col_nxt = r_col + col_t'(1);
                end
            end
            ST_SHIFT: begin
                if (r_col == LAST_COL) begin
                    w_col_nxt = '0;
                    if (r_row == row_t'(1)) begin
                        w_state_nxt = ST_ZERO_TOP;
                        w_row_nxt   = '0;
                    end else begin
                        w_row_nxt = r_row - row_t'(1);
                    end
                end else begin
                    w_col_nxt = r_col + col_t'(1);
                end
            end
            ST_ZERO_TOP: begin
                if (r_col == LAST_COL) begin
                    w_state_nxt = ST_IDLE;
                    w_col_nxt   = '0;
                    w_done      = 1'b1;
                end else begin
                    w_col_nxt = r_col + col_t'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy           = (r_state != ST_IDLE);
        o_wr_ready       = (r_state == ST_IDLE);
        o_cmd_we         = (r_state != ST_IDLE);
        o_cmd_from_above = (r_state == ST_SHIFT);
        o_cmd_row        = r_row;
        o_cmd_col        = r_col;
        o_op_done        = r_op_done;
    end

endmodule

// File: rtl/tetris_board_renderer.sv
// Tetris playfield storage and pixel source for the video driver.
//   CLOCK_50, reset  : clock, synchronous active-high reset
//   i_x, i_y         : logical scan position from the video driver
//   o_r, o_g, o_b    : colour, valid two clock edges after i_x/i_y are applied
//   bus (slave)      : cell write port and bulk clear/collapse control
module tetris_board_renderer
    import tetris_pkg::*;
#(
    parameter int CELL_LOG2 = 2,
    parameter int X0        = 60,
    parameter int Y0        = 20,
    parameter int BORDER    = 2
)(
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [9:0] i_x,
    input  logic [8:0] i_y,
    output logic [7:0] o_r,
    output logic [7:0] o_g,
    output logic [7:0] o_b,
    tetris_board_renderer_if.slave bus
);

    localparam logic [9:0] BX_LO = 10'(X0);
    localparam logic [9:0] BY_LO = 10'(Y0);
    localparam logic [9:0] FX_LO = 10'(X0 - BORDER);
    localparam logic [9:0] FY_LO = 10'(Y0 - BORDER);
    localparam logic [9:0] PX_W  = 10'(BOARD_W << CELL_LOG2);
    localparam logic [9:0] PX_H  = 10'(BOARD_H << CELL_LOG2);
    localparam logic [9:0] FR_W  = 10'((BOARD_W << CELL_LOG2) + 2 * BORDER);
    localparam logic [9:0] FR_H  = 10'((BOARD_H << CELL_LOG2) + 2 * BORDER);

    cell_color_t r_cells [BOARD_H][BOARD_W];

    logic w_cmd_we, w_cmd_from_above;
    row_t w_cmd_row;
    col_t w_cmd_col;

    board_bulk_fsm u_bulk_fsm (
        .clk              (CLOCK_50),
        .reset            (reset),
        .i_clr_req        (bus.clr_req),
        .i_shift_req      (bus.shift_req),
        .i_shift_row      (bus.shift_row),
        .o_busy           (bus.busy),
        .o_op_done        (bus.op_done),
        .o_wr_ready       (bus.wr_ready),
        .o_cmd_we         (w_cmd_we),
        .o_cmd_from_above (w_cmd_from_above),
        .o_cmd_row        (w_cmd_row),
        .o_cmd_col        (w_cmd_col)
    );

    // The write port is only open in IDLE and bulk commands only run outside
    // IDLE, so the two never collide on the same edge.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int rr = 0; rr < BOARD_H; rr++)
                for (int cc = 0; cc < BOARD_W; cc++)
                    r_cells[rr][cc] <= EMPTY;
        end else if (w_cmd_we) begin
            if (w_cmd_from_above)
                r_cells[w_cmd_row][w_cmd_col] <= r_cells[w_cmd_row - row_t'(1)][w_cmd_col];
            else
                r_cells[w_cmd_row][w_cmd_col] <= EMPTY;
        end else if (bus.wr_valid && bus.wr_ready &&
                     (bus.wr_col <= LAST_COL) && (bus.wr_row <= LAST_ROW)) begin
            r_cells[bus.wr_row][bus.wr_col] <= cell_color_t'(bus.wr_color);
        end
    end

    // Offsets wrap for positions left/above the box, so a single unsigned
    // compare covers both edges of each range.
    logic [9:0] w_dx, w_dy, w_fx, w_fy;
    logic       w_in_board, w_in_box;

    always_comb begin
        w_dx       = i_x - BX_LO;
        w_dy       = {1'b0, i_y} - BY_LO;
        w_fx       = i_x - FX_LO;
        w_fy       = {1'b0, i_y} - FY_LO;
        w_in_board = (w_dx < PX_W) && (w_dy < PX_H);
        w_in_box   = (w_fx < FR_W) && (w_fy < FR_H);
    end

    logic        r_s1_in_board, r_s1_in_frame;
    row_t        r_s1_row;
    col_t        r_s1_col;
    logic [23:0] r_rgb;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_s1_in_board <= 1'b0;
            r_s1_in_frame <= 1'b0;
            r_s1_row      <= '0;
            r_s1_col      <= '0;
        end else begin
            r_s1_in_board <= w_in_board;
            r_s1_in_frame <= w_in_box && !w_in_board;
            // Park the cell index at (0,0) off-board so the lookup stays in range.
            r_s1_row      <= w_in_board ? row_t'(w_dy >> CELL_LOG2) : '0;
            r_s1_col      <= w_in_board ? col_t'(w_dx >> CELL_LOG2) : '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset)
            r_rgb <= '0;
        else if (r_s1_in_board)
            r_rgb <= palette(r_cells[r_s1_row][r_s1_col]);
        else if (r_s1_in_frame)
            r_rgb <= RGB_BORDER;
        else
            r_rgb <= RGB_BACKGROUND;
    end

    assign o_r = r_rgb[23:16];
    assign o_g = r_rgb[15:8];
    assign o_b = r_rgb[7:0];

endmodule

// File: tb/tb_tetris_board_renderer.sv
module tb_tetris_board_renderer;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] r, g, b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tetris_board_renderer_if bus();

    tetris_board_renderer dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .i_x      (x),
        .i_y      (y),
        .o_r      (r),
        .o_g      (g),
        .o_b      (b),
        .bus      (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input string tag, input int px, input int py, input logic [23:0] exp);
        x = 10'(px);
        y = 9'(py);
        tick();
        tick();
        check(tag, {8'h00, r, g, b}, {8'h00, exp});
    endtask

    task automatic wr(input int col, input int row, input int color);
        bus.wr_valid = 1'b1;
        bus.wr_col   = 4'(col);
        bus.wr_row   = 5'(row);
        bus.wr_color = 3'(color);
        tick();
        bus.wr_valid = 1'b0;
    endtask

    // Runs until busy drops or the budget expires; optionally pulses clr_req mid-op.
    task automatic run_op(input int budget, input int pulse_at,
                          output int cycles, output int dones, output int rdy_hi);
        cycles = 0;
        dones  = 0;
        rdy_hi = 0;
        while (bus.busy && cycles < budget) begin
            if (bus.wr_ready) rdy_hi++;
            if (cycles == pulse_at) bus.clr_req = 1'b1;
            tick();
            bus.clr_req = 1'b0;
            cycles++;
            if (bus.op_done) dones++;
        end
    endtask

    int cyc, dn, rdy, extra;

    initial begin
        reset = 1'b1;
        x = '0;
        y = '0;
        bus.wr_valid = 1'b0; bus.wr_col = '0; bus.wr_row = '0; bus.wr_color = '0;
        bus.clr_req = 1'b0; bus.shift_req = 1'b0; bus.shift_row = '0;
        tick(); tick(); tick();
        reset = 1'b0;

        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_op_done", 32'(bus.op_done), 32'd0);
        check("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        check("rst_rgb", {8'h00, r, g, b}, 32'h0);

        // exact two-edge latency
        x = 10'd60; y = 9'd20;
        tick();
        check("lat_edge1", {8'h00, r, g, b}, 32'h0);
        tick();
        check("lat_edge2", {8'h00, r, g, b}, 32'h202020);
        pix("frame_left", 58, 30, 24'h808080);
        pix("outside_left", 57, 30, 24'h000000);
        pix("frame_right", 100, 99, 24'h808080);
        pix("frame_bottom", 80, 101, 24'h808080);
        pix("outside_bottom", 80, 102, 24'h000000);

        check("wr_ready_idle", 32'(bus.wr_ready), 32'd1);
        wr(0, 0, 1);
        pix("cell00_I", 63, 23, 24'h00FFFF);
        pix("cell01_empty", 64, 23, 24'h202020);
        wr(9, 19, 5);
        pix("cell_19_9_Z", 99, 99, 24'hF00000);

        for (int rr = 17; rr <= 19; rr++)
            for (int cc = 0; cc < 10; cc++)
                wr(cc, rr, rr - 15);
        pix("row19_filled", 99, 99, 24'h00F000);

        bus.shift_req = 1'b1; bus.shift_row = 5'd19;
        tick();
        bus.shift_req = 1'b0;
        check("sh19_busy", 32'(bus.busy), 32'd1);
        run_op(1000, -1, cyc, dn, rdy);
        check("sh19_cycles", 32'(cyc), 32'd200);
        check("sh19_done", 32'(dn), 32'd1);
        check("sh19_ready_low", 32'(rdy), 32'd0);
        tick();
        check("sh19_done_pulse", 32'(bus.op_done), 32'd0);
        pix("sh19_row19", 80, 96, 24'hA000F0);
        pix("sh19_row18", 96, 92, 24'hFFFF00);
        pix("sh19_row17", 60, 88, 24'h202020);
        pix("sh19_row1", 60, 24, 24'h00FFFF);
        pix("sh19_row0", 60, 20, 24'h202020);

        wr(3, 0, 6);
        pix("row0_c3_J", 72, 20, 24'h0000F0);
        bus.shift_req = 1'b1; bus.shift_row = 5'd0;
        tick();
        bus.shift_req = 1'b0;
        check("sh0_busy", 32'(bus.busy), 32'd1);
        run_op(1000, -1, cyc, dn, rdy);
        check("sh0_cycles", 32'(cyc), 32'd10);
        check("sh0_done", 32'(dn), 32'd1);
        pix("sh0_row0", 72, 20, 24'h202020);
        pix("sh0_row1", 60, 24, 24'h00FFFF);
        pix("sh0_row19", 80, 96, 24'hA000F0);

        bus.shift_req = 1'b1; bus.shift_row = 5'd25;
        tick();
        bus.shift_req = 1'b0;
        check("sh25_busy", 32'(bus.busy), 32'd0);
        extra = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.op_done || bus.busy) extra++;
            tick();
        end
        check("sh25_quiet", 32'(extra), 32'd0);
        pix("sh25_row1", 60, 24, 24'h00FFFF);

        bus.clr_req = 1'b1; bus.shift_req = 1'b1; bus.shift_row = 5'd5;
        tick();
        bus.clr_req = 1'b0; bus.shift_req = 1'b0;
        check("clr_busy", 32'(bus.busy), 32'd1);
        run_op(1000, 50, cyc, dn, rdy);
        check("clr_cycles", 32'(cyc), 32'd200);
        check("clr_done", 32'(dn), 32'd1);
        check("clr_ready_low", 32'(rdy), 32'd0);
        tick();
        check("clr_no_second", 32'(bus.busy), 32'd0);
        pix("clr_row1", 60, 24, 24'h202020);
        pix("clr_row19", 80, 96, 24'h202020);
        pix("clr_row18", 96, 92, 24'h202020);

        // write accepted on the same edge as a collapse request, then shifted down
        bus.wr_valid = 1'b1; bus.wr_col = 4'd0; bus.wr_row = 5'd0; bus.wr_color = 3'd1;
        bus.shift_req = 1'b1; bus.shift_row = 5'd1;
        tick();
        bus.wr_valid = 1'b0; bus.shift_req = 1'b0;
        run_op(1000, -1, cyc, dn, rdy);
        check("sh1_cycles", 32'(cyc), 32'd20);
        pix("sh1_row1", 60, 24, 24'h00FFFF);
        pix("sh1_row0", 60, 20, 24'h202020);

        check("oor_ready", 32'(bus.wr_ready), 32'd1);
        wr(12, 3, 7);
        wr(2, 21, 7);
        check("oor_busy", 32'(bus.busy), 32'd0);
        pix("oor_row3_c0", 60, 32, 24'h202020);
        pix("oor_row3_c9", 96, 32, 24'h202020);
        pix("oor_row1", 60, 24, 24'h00FFFF);

        wr(4, 10, 7);
        pix("cell_10_4_L", 76, 60, 24'hF0A000);
        bus.shift_req = 1'b1; bus.shift_row = 5'd15;
        tick();
        bus.shift_req = 1'b0;
        check("sh15_busy", 32'(bus.busy), 32'd1);
        for (int k = 0; k < 20; k++) tick();
        reset = 1'b1;
        tick();
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_op_done", 32'(bus.op_done), 32'd0);
        check("abort_rgb", {8'h00, r, g, b}, 32'h0);
        reset = 1'b0;
        extra = 0;
        for (int k = 0; k < 200; k++) begin
            if (bus.op_done) extra++;
            tick();
        end
        check("abort_no_done", 32'(extra), 32'd0);
        pix("abort_cell_10_4", 76, 60, 24'h202020);
        pix("abort_row1", 60, 24, 24'h202020);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
